// File: rtl/multicycle_fsm_if.sv
// Control-unit bus of the multicycle ARM-subset processor: decoded instruction
// fields and ALU flags towards the FSM, datapath control strobes and debug state back.
interface multicycle_fsm_if;
    // Timing contract (no valid/ready): the datapath holds Cond/Op/Funct/Rd/Mult
    // stable from the FETCH cycle of an instruction until the next FETCH. ALUFlags
    // is sampled on the rising edge that ends EXECR/EXECI (or the last MULEX cycle).
    // Every output is meaningful on every cycle.
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       Mult;
    logic [3:0] ALUFlags;

    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       ALUOp;
    logic [3:0] State;

    modport master (
        output Cond, Op, Funct, Rd, Mult, ALUFlags,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
        input  PCWrite, RegWrite, MemWrite, ALUOp, State
    );

    modport slave (
        input  Cond, Op, Funct, Rd, Mult, ALUFlags,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
        output PCWrite, RegWrite, MemWrite, ALUOp, State
    );
endinterface

// File: rtl/multicycle_fsm.sv
// Multicycle ARM-subset main controller with conditional execution and NZCV flags.
// Define MULTICYCLE_FSM_MUL_EN to add the 3-cycle MULEX state for multiply encodings.
module multicycle_fsm (
    input  logic            clk,
    input  logic            reset,
    multicycle_fsm_if.slave bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
`ifdef MULTICYCLE_FSM_MUL_EN
        , MULEX = 4'd10
`endif
    } state_t;

    // Ungated per-state controls; the write strobes are qualified by CondEx at the output.
    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       pc_fetch;
        logic       pc_branch;
        logic       reg_wb;
        logic       mem_wr;
    } ctrl_t;

    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.ir_write   = 1'b1;
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.pc_fetch   = 1'b1;
            end
            DECODE: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            MEMADR: c.alu_src_b = 2'b01;
            MEMRD:  c.adr_src   = 1'b1;
            MEMWB: begin
                c.result_src = 2'b01;
                c.reg_wb     = 1'b1;
            end
            MEMWR: begin
                c.adr_src = 1'b1;
                c.mem_wr  = 1'b1;
            end
            EXECR:  c.alu_op = 1'b1;
            EXECI: begin
                c.alu_src_b = 2'b01;
                c.alu_op    = 1'b1;
            end
            ALUWB:  c.reg_wb = 1'b1;
            BRANCH: begin
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
                c.pc_branch  = 1'b1;
            end
`ifdef MULTICYCLE_FSM_MUL_EN
            MULEX:  c.alu_op = 1'b1;
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic r;
        {n, z, c, v} = nzcv;
        case (cond)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = c;
            4'b0011: r = ~c;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = c & ~z;
            4'b1001: r = ~c | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = ~z & (n == v);
            4'b1101: r = z | (n != v);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       cond_ex;
    logic       rd_is_pc;

`ifdef MULTICYCLE_FSM_MUL_EN
    logic [1:0] mul_cnt_q, mul_cnt_d;
    logic       is_mul;
    assign is_mul = (bus.Funct[4:1] == 4'b0000) && bus.Mult;
`else
    // Multiply encodings simply execute as EXECR here.
    logic unused_mul;
    assign unused_mul = ^{bus.Mult, bus.Funct[4:1]};
`endif

    always_comb begin
        cond_ex = cond_check(bus.Cond, flags_q);
    end

    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
`ifdef MULTICYCLE_FSM_MUL_EN
        mul_cnt_d = mul_cnt_q;
`endif
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (bus.Op)
                    2'b01: state_d = MEMADR;
                    2'b10: state_d = BRANCH;
                    2'b00: begin
                        if (bus.Funct[5]) begin
                            state_d = EXECI;
`ifdef MULTICYCLE_FSM_MUL_EN
                        end else if (is_mul) begin
                            state_d   = MULEX;
                            mul_cnt_d = 2'd0;
`endif
                        end else begin
                            state_d = EXECR;
                        end
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: state_d = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_d = MEMWB;
            EXECR, EXECI: begin
                state_d = ALUWB;
                if (bus.Funct[0] && cond_ex) flags_d = bus.ALUFlags;
            end
`ifdef MULTICYCLE_FSM_MUL_EN
            MULEX: begin
                if (mul_cnt_q == 2'd2) begin
                    state_d   = ALUWB;
                    mul_cnt_d = 2'd0;
                    if (bus.Funct[0] && cond_ex) flags_d = bus.ALUFlags;
                end else begin
                    mul_cnt_d = mul_cnt_q + 2'd1;
                end
            end
`endif
            default: state_d = FETCH;
        endcase
        ctrl_d = ctrl_for(state_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            flags_q <= 4'b0000;
            ctrl_q  <= ctrl_for(FETCH);
`ifdef MULTICYCLE_FSM_MUL_EN
            mul_cnt_q <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            ctrl_q  <= ctrl_d;
`ifdef MULTICYCLE_FSM_MUL_EN
            mul_cnt_q <= mul_cnt_d;
`endif
        end
    end

    // A write-back to R15 becomes a (conditional) PC write instead of a register write.
    assign rd_is_pc = (bus.Rd == 4'hF);

    assign bus.IRWrite   = ctrl_q.ir_write;
    assign bus.AdrSrc    = ctrl_q.adr_src;
    assign bus.ALUSrcA   = ctrl_q.alu_src_a;
    assign bus.ALUSrcB   = ctrl_q.alu_src_b;
    assign bus.ResultSrc = ctrl_q.result_src;
    assign bus.ALUOp     = ctrl_q.alu_op;
    assign bus.PCWrite   = ctrl_q.pc_fetch
                         | (cond_ex & (ctrl_q.pc_branch | (ctrl_q.reg_wb & rd_is_pc)));
    assign bus.RegWrite  = cond_ex & ctrl_q.reg_wb & ~rd_is_pc;
    assign bus.MemWrite  = cond_ex & ctrl_q.mem_wr;
    assign bus.State     = state_q;

endmodule

// File: tb/tb_multicycle_fsm.sv
// Directed scoreboard bench for multicycle_fsm: the driver queues one expected
// record per cycle, a negedge monitor pops and compares every cycle.
module tb_multicycle_fsm;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [14:0] exp_q[$];
    string       tag_q[$];

    multicycle_fsm_if bus_if ();

    multicycle_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected record: {State, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
    // PCWrite, RegWrite, MemWrite, ALUOp}; write strobes are hand-supplied per cycle.
    function automatic logic [14:0] rec(input logic [3:0] st, input logic pcw,
                                        input logic regw, input logic memw);
        logic       ir, adr, sa, op;
        logic [1:0] sb, rs;
        ir = 1'b0; adr = 1'b0; sa = 1'b0; op = 1'b0; sb = 2'b00; rs = 2'b00;
        case (st)
            4'd0:  begin ir = 1'b1; sa = 1'b1; sb = 2'b10; rs = 2'b10; end
            4'd1:  begin sa = 1'b1; sb = 2'b10; rs = 2'b10; end
            4'd2:  sb = 2'b01;
            4'd3:  adr = 1'b1;
            4'd4:  rs = 2'b01;
            4'd5:  adr = 1'b1;
            4'd6:  op = 1'b1;
            4'd7:  begin sb = 2'b01; op = 1'b1; end
            4'd9:  begin sb = 2'b01; rs = 2'b10; end
            4'd10: op = 1'b1;
            default: ;
        endcase
        return {st, ir, adr, sa, sb, rs, pcw, regw, memw, op};
    endfunction

    task automatic e(input string tag, input logic [3:0] st, input logic pcw,
                     input logic regw, input logic memw);
        exp_q.push_back(rec(st, pcw, regw, memw));
        tag_q.push_back(tag);
    endtask

    task automatic fd(input string tag);
        e(tag, 4'd0, 1'b1, 1'b0, 1'b0);
        e(tag, 4'd1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_instr(input logic [3:0] cond, input logic [1:0] op,
                             input logic [5:0] funct, input logic [3:0] rd,
                             input logic mult, input logic [3:0] flags);
        bus_if.Cond     = cond;
        bus_if.Op       = op;
        bus_if.Funct    = funct;
        bus_if.Rd       = rd;
        bus_if.Mult     = mult;
        bus_if.ALUFlags = flags;
    endtask

    // Leaves the bench at posedge+1 of the cycle following the last queued record.
    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d records left, required 0", exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [14:0] exp_v;
            logic [14:0] got_v;
            string       tag;
            exp_v = exp_q.pop_front();
            tag   = tag_q.pop_front();
            got_v = {bus_if.State, bus_if.IRWrite, bus_if.AdrSrc, bus_if.ALUSrcA,
                     bus_if.ALUSrcB, bus_if.ResultSrc, bus_if.PCWrite,
                     bus_if.RegWrite, bus_if.MemWrite, bus_if.ALUOp};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL %s: got state=%0d ctrl=%b, required state=%0d ctrl=%b",
                         tag, got_v[14:11], got_v[10:0], exp_v[14:11], exp_v[10:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        set_instr(4'hE, 2'b00, 6'b000000, 4'h0, 1'b0, 4'h0);
        e("reset_hold", 4'd0, 1'b1, 1'b0, 1'b0);
        e("reset_hold", 4'd0, 1'b1, 1'b0, 1'b0);
        drain();
        reset = 1'b0;

        // LDR R3
        set_instr(4'hE, 2'b01, 6'b011001, 4'h3, 1'b0, 4'h0);
        fd("ldr");
        e("ldr", 4'd2, 1'b0, 1'b0, 1'b0);
        e("ldr", 4'd3, 1'b0, 1'b0, 1'b0);
        e("ldr", 4'd4, 1'b0, 1'b1, 1'b0);
        drain();

        // STREQ with Z=0 (flags cleared by reset)
        set_instr(4'h0, 2'b01, 6'b011000, 4'h3, 1'b0, 4'h0);
        fd("streq_skip");
        e("streq_skip", 4'd2, 1'b0, 1'b0, 1'b0);
        e("streq_skip", 4'd5, 1'b0, 1'b0, 1'b0);
        drain();

        set_instr(4'hE, 2'b01, 6'b011000, 4'h3, 1'b0, 4'h0);
        fd("str");
        e("str", 4'd2, 1'b0, 1'b0, 1'b0);
        e("str", 4'd5, 1'b0, 1'b0, 1'b1);
        drain();

        // SUBS -> flags 0100
        set_instr(4'hE, 2'b00, 6'b000101, 4'h2, 1'b0, 4'b0100);
        fd("subs");
        e("subs", 4'd6, 1'b0, 1'b0, 1'b0);
        e("subs", 4'd8, 1'b0, 1'b1, 1'b0);
        drain();

        set_instr(4'h0, 2'b10, 6'b000000, 4'h0, 1'b0, 4'h0);
        fd("beq_taken");
        e("beq_taken", 4'd9, 1'b1, 1'b0, 1'b0);
        drain();

        set_instr(4'h1, 2'b10, 6'b000000, 4'h0, 1'b0, 4'h0);
        fd("bne_not_taken");
        e("bne_not_taken", 4'd9, 1'b0, 1'b0, 1'b0);
        drain();

        // ADDSNE is skipped: no write, flags hold at 0100
        set_instr(4'h1, 2'b00, 6'b001001, 4'h2, 1'b0, 4'b0000);
        fd("addsne_skip");
        e("addsne_skip", 4'd6, 1'b0, 1'b0, 1'b0);
        e("addsne_skip", 4'd8, 1'b0, 1'b0, 1'b0);
        drain();

        // ADD without S: flags hold
        set_instr(4'hE, 2'b00, 6'b001000, 4'h5, 1'b0, 4'b0000);
        fd("add_nos");
        e("add_nos", 4'd6, 1'b0, 1'b0, 1'b0);
        e("add_nos", 4'd8, 1'b0, 1'b1, 1'b0);
        drain();

        set_instr(4'h0, 2'b10, 6'b000000, 4'h0, 1'b0, 4'h0);
        fd("beq_flags_held");
        e("beq_flags_held", 4'd9, 1'b1, 1'b0, 1'b0);
        drain();

        set_instr(4'hE, 2'b00, 6'b001000, 4'hF, 1'b0, 4'h0);
        fd("add_pc");
        e("add_pc", 4'd6, 1'b0, 1'b0, 1'b0);
        e("add_pc", 4'd8, 1'b1, 1'b0, 1'b0);
        drain();

        set_instr(4'h1, 2'b00, 6'b001000, 4'hF, 1'b0, 4'h0);
        fd("addne_pc_skip");
        e("addne_pc_skip", 4'd6, 1'b0, 1'b0, 1'b0);
        e("addne_pc_skip", 4'd8, 1'b0, 1'b0, 1'b0);
        drain();

        // SUBS immediate -> flags 1000
        set_instr(4'hE, 2'b00, 6'b100101, 4'h2, 1'b0, 4'b1000);
        fd("subs_imm");
        e("subs_imm", 4'd7, 1'b0, 1'b0, 1'b0);
        e("subs_imm", 4'd8, 1'b0, 1'b1, 1'b0);
        drain();

        set_instr(4'hB, 2'b10, 6'b000000, 4'h0, 1'b0, 4'h0);
        fd("blt_taken");
        e("blt_taken", 4'd9, 1'b1, 1'b0, 1'b0);
        drain();

        set_instr(4'h0, 2'b10, 6'b000000, 4'h0, 1'b0, 4'h0);
        fd("beq_not_taken");
        e("beq_not_taken", 4'd9, 1'b0, 1'b0, 1'b0);
        drain();

        set_instr(4'hE, 2'b01, 6'b011001, 4'hF, 1'b0, 4'h0);
        fd("ldr_pc");
        e("ldr_pc", 4'd2, 1'b0, 1'b0, 1'b0);
        e("ldr_pc", 4'd3, 1'b0, 1'b0, 1'b0);
        e("ldr_pc", 4'd4, 1'b1, 1'b0, 1'b0);
        drain();

        set_instr(4'hE, 2'b11, 6'b000000, 4'h0, 1'b0, 4'h0);
        fd("undef_op");
        drain();

        set_instr(4'hE, 2'b00, 6'b000000, 4'h4, 1'b1, 4'h0);
        fd("mul");
`ifdef MULTICYCLE_FSM_MUL_EN
        e("mul", 4'd10, 1'b0, 1'b0, 1'b0);
        e("mul", 4'd10, 1'b0, 1'b0, 1'b0);
        e("mul", 4'd10, 1'b0, 1'b0, 1'b0);
`else
        e("mul", 4'd6, 1'b0, 1'b0, 1'b0);
`endif
        e("mul", 4'd8, 1'b0, 1'b1, 1'b0);
        drain();

        // MULS -> flags 0100
        set_instr(4'hE, 2'b00, 6'b000001, 4'h4, 1'b1, 4'b0100);
        fd("muls");
`ifdef MULTICYCLE_FSM_MUL_EN
        e("muls", 4'd10, 1'b0, 1'b0, 1'b0);
        e("muls", 4'd10, 1'b0, 1'b0, 1'b0);
        e("muls", 4'd10, 1'b0, 1'b0, 1'b0);
`else
        e("muls", 4'd6, 1'b0, 1'b0, 1'b0);
`endif
        e("muls", 4'd8, 1'b0, 1'b1, 1'b0);
        drain();

        set_instr(4'h0, 2'b10, 6'b000000, 4'h0, 1'b0, 4'h0);
        fd("beq_after_muls");
        e("beq_after_muls", 4'd9, 1'b1, 1'b0, 1'b0);
        drain();

        // Asynchronous reset in the middle of an LDR (during MEMRD)
        set_instr(4'hE, 2'b01, 6'b011001, 4'h3, 1'b0, 4'h0);
        fd("ldr_pre_reset");
        e("ldr_pre_reset", 4'd2, 1'b0, 1'b0, 1'b0);
        drain();
        checks++;
        if (bus_if.State !== 4'd3) begin
            errors++;
            $display("FAIL in_memrd: got state=%0d, required 3", bus_if.State);
        end
        #1 reset = 1'b1;
        e("async_reset", 4'd0, 1'b1, 1'b0, 1'b0);
        e("async_reset", 4'd0, 1'b1, 1'b0, 1'b0);
        drain();
        reset = 1'b0;

        set_instr(4'hE, 2'b00, 6'b001000, 4'h6, 1'b0, 4'h0);
        fd("add_after_reset");
        e("add_after_reset", 4'd6, 1'b0, 1'b0, 1'b0);
        e("add_after_reset", 4'd8, 1'b0, 1'b1, 1'b0);
        drain();

        // Flags were 0100 before reset; reset clears them so EQ fails
        set_instr(4'h0, 2'b10, 6'b000000, 4'h0, 1'b0, 4'h0);
        fd("beq_flags_reset");
        e("beq_flags_reset", 4'd9, 1'b0, 1'b0, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
